// File: rtl/rand_range_sampler_pkg.sv
// rand_pkg: shared widths, defaults and FSM encoding for the range sampler
package rand_pkg;
   localparam int RAND_W = 16;
   localparam int K_W = 5;
   localparam int DEF_MAX_TRIES = 8;
   typedef enum logic {ST_IDLE, ST_SAMPLE} state_t;
endpackage

// File: rtl/rand_range_sampler_if.sv
// rand_range_sampler_if: request/result bundle between a client and the sampler
interface rand_range_sampler_if
   import rand_pkg::*;
#(
   parameter int WIDTH = RAND_W
);
   logic [WIDTH-1:0] rand_in;
   logic             request;
   logic [WIDTH-1:0] bound;
   logic [WIDTH-1:0] value;
   logic             valid;
   logic             busy;
   logic             error;
   modport master (output rand_in, request, bound, input value, valid, busy, error);
   modport slave  (input rand_in, request, bound, output value, valid, busy, error);
endinterface

// File: rtl/rand_range_sampler_range_width_calc.sv
// range_width_calc: k = number of bits needed to represent bound-1
module range_width_calc
   import rand_pkg::*;
#(
   parameter int WIDTH = RAND_W
) (
   input  logic [WIDTH-1:0] bound,
   output logic [K_W-1:0]   k
);
   logic [WIDTH-1:0] nm1;
   // priority encode the highest set bit of bound-1; bound=1 yields k=0
   always_comb begin
      nm1 = bound - WIDTH'(1);
      k = '0;
      for (int i = 0; i < WIDTH; i++)
         if (nm1[i]) k = K_W'(i + 1);
   end
endmodule

// File: rtl/rand_range_sampler.sv
// rand_range_sampler: unbiased [0, bound) integers from a PRNG word via mask rejection
module rand_range_sampler
   import rand_pkg::*;
#(
   parameter int WIDTH = RAND_W,
   parameter int MAX_TRIES = DEF_MAX_TRIES
) (
   input  logic clk,
   input  logic rst_n,
   rand_range_sampler_if.slave bus
);
   state_t           state, state_nx;
   logic [WIDTH-1:0] bound_reg, bound_nx;
   logic [K_W-1:0]   k_reg, k_nx, k_calc;
   logic [7:0]       try_cnt, try_nx;
   logic [WIDTH-1:0] value, value_nx;
   logic             valid, valid_nx;
   logic             error, error_nx;
   logic [K_W-1:0]   sh;
   logic [WIDTH-1:0] cand;

   range_width_calc #(.WIDTH(WIDTH)) u_kcalc (.bound(bus.bound), .k(k_calc));

   // keep the high bits of the PRNG word since LCG low bits are weak
   always_comb begin
      sh = K_W'(WIDTH) - k_reg;
      cand = (k_reg == '0) ? '0 : bus.rand_in >> sh;
   end

   // next-state: accept in IDLE, one rejection attempt per cycle in SAMPLE
   always_comb begin
      state_nx = state;
      bound_nx = bound_reg;
      k_nx = k_reg;
      try_nx = try_cnt;
      value_nx = value;
      valid_nx = 1'b0;
      error_nx = 1'b0;
      if (state == ST_IDLE) begin
         if (bus.request && bus.bound == '0) error_nx = 1'b1;
         else if (bus.request) begin
            bound_nx = bus.bound;
            k_nx = k_calc;
            try_nx = '0;
            state_nx = ST_SAMPLE;
         end
      end else if (cand < bound_reg) begin
         value_nx = cand;
         valid_nx = 1'b1;
         state_nx = ST_IDLE;
      end else if (try_cnt == 8'(MAX_TRIES - 1)) begin
         // cand < 2^k < 2*bound, so one subtraction lands in range
         value_nx = cand - bound_reg;
         valid_nx = 1'b1;
         state_nx = ST_IDLE;
      end else try_nx = try_cnt + 8'd1;
   end

   // state and result registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         bound_reg <= '0;
         k_reg <= '0;
         try_cnt <= '0;
         value <= '0;
         valid <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= state_nx;
         bound_reg <= bound_nx;
         k_reg <= k_nx;
         try_cnt <= try_nx;
         value <= value_nx;
         valid <= valid_nx;
         error <= error_nx;
      end
   end

   assign bus.value = value;
   assign bus.valid = valid;
   assign bus.error = error;
   assign bus.busy = (state == ST_SAMPLE);
endmodule

// File: tb/tb_rand_range_sampler.sv
// tb_rand_range_sampler: directed vectors with hand-computed results
module tb_rand_range_sampler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   rand_range_sampler_if #(.WIDTH(16)) bus ();

   rand_range_sampler #(.WIDTH(16), .MAX_TRIES(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start(input logic [15:0] b);
      @(negedge clk);
      bus.request = 1'b1;
      bus.bound = b;
      @(negedge clk);
      bus.request = 1'b0;
      bus.bound = 16'h0;
   endtask

   initial begin
      bus.request = 1'b0;
      bus.bound = 16'h0;
      bus.rand_in = 16'h0;
      #12;
      chk("rst_value", bus.value, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_error", bus.error, 0);
      @(negedge clk);
      rst_n = 1'b1;

      start(16'd6);
      chk("t1_busy_accept", bus.busy, 1);
      bus.rand_in = 16'hA000;
      @(negedge clk);
      chk("t1_valid", bus.valid, 1);
      chk("t1_value", bus.value, 5);
      chk("t1_busy", bus.busy, 0);
      @(negedge clk);
      chk("t1_valid_pulse", bus.valid, 0);

      start(16'd6);
      bus.rand_in = 16'hE000;
      @(negedge clk);
      chk("t2_reject_valid", bus.valid, 0);
      chk("t2_reject_busy", bus.busy, 1);
      bus.rand_in = 16'h2000;
      @(negedge clk);
      chk("t2_valid", bus.valid, 1);
      chk("t2_value", bus.value, 1);

      start(16'd6);
      bus.rand_in = 16'hFFFF;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("t3_no_valid", bus.valid, 0);
      end
      @(negedge clk);
      chk("t3_fb_valid", bus.valid, 1);
      chk("t3_fb_value", bus.value, 1);
      chk("t3_fb_busy", bus.busy, 0);

      start(16'd1);
      bus.rand_in = 16'hFFFF;
      @(negedge clk);
      chk("t4_valid", bus.valid, 1);
      chk("t4_value", bus.value, 0);

      start(16'hFFFF);
      bus.rand_in = 16'hFFFF;
      @(negedge clk);
      chk("t5_reject", bus.valid, 0);
      bus.rand_in = 16'h1234;
      @(negedge clk);
      chk("t5_valid", bus.valid, 1);
      chk("t5_value", bus.value, 16'h1234);

      start(16'd0);
      chk("t6_error", bus.error, 1);
      chk("t6_no_valid", bus.valid, 0);
      chk("t6_busy", bus.busy, 0);
      chk("t6_value_hold", bus.value, 16'h1234);
      @(negedge clk);
      chk("t6_error_pulse", bus.error, 0);

      start(16'd6);
      bus.rand_in = 16'hFFFF;
      @(negedge clk);
      chk("t7_busy_before", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_rst_busy", bus.busy, 0);
      chk("t7_rst_value", bus.value, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t7_no_valid", bus.valid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
